// File: rtl/note_recorder.sv
// Records live keyed notes as (note, octave, duration) byte triples, then writes the length byte at address 0.
// Latency: a triple is written on the 3 cycles after its entry closes; rec_done pulses the cycle after the length write.
// Backpressure: none; the memory write port accepts one byte every cycle, and TICK_CYCLES >= 4 keeps triple writes from overlapping.
module note_recorder #(
  parameter int TICK_CYCLES = 100,
  parameter int ADDR_W      = 10,
  parameter int MAX_ENTRIES = 84
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rec_start,
  input  logic              rec_stop,
  input  logic [2:0]        note_in,
  input  logic [2:0]        octave_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              recording,
  output logic              full,
  output logic              rec_done
);

  localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [7:0] MAX_LAST = 8'(MAX_ENTRIES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    TIMING = 2'd2,
    FINAL  = 2'd3
  } state_t;

  state_t state;
  state_t stateNext;

  // Entry currently being timed
  logic [2:0]        curNote;
  logic [2:0]        curOct;
  logic [TICK_W-1:0] tickCnt;
  logic [7:0]        units;

  // Recording bookkeeping
  logic [7:0]        entryCnt;
  logic [ADDR_W-1:0] baseAddr;
  logic              fullReg;
  logic              recDoneReg;

  // Closed triple waiting to be written; wrPhase 0 = writer idle, 1..3 = byte being written
  logic [2:0]        holdNote;
  logic [2:0]        holdOct;
  logic [7:0]        holdUnits;
  logic [1:0]        wrPhase;

  // Control strobes from the FSM
  logic              doArm;
  logic              doLatch;
  logic              doCount;
  logic              doClose;
  logic              doFull;
  logic              writeLen;
  logic [7:0]        closeUnits;

  // Normalised input: silence always reads as (0, 1); octaves outside 1..3 read as 3
  logic [2:0]        inOct;
  logic              inChanged;
  logic              tickWrap;
  logic [7:0]        lenByte;

  // Coerce the live input and compare it against the entry being timed
  always_comb begin
    inOct = 3'd3;
    if (note_in == 3'd0) begin
      inOct = 3'd1;
    end else if ((octave_in >= 3'd1) && (octave_in <= 3'd3)) begin
      inOct = octave_in;
    end
    inChanged = (note_in != curNote) || (inOct != curOct);
    tickWrap  = (tickCnt == TICK_LAST);
    lenByte   = 8'd1 + entryCnt + entryCnt + entryCnt;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic and per-cycle control strobes
  always_comb begin
    stateNext  = state;
    doArm      = 1'b0;
    doLatch    = 1'b0;
    doCount    = 1'b0;
    doClose    = 1'b0;
    doFull     = 1'b0;
    writeLen   = 1'b0;
    closeUnits = units;
    case (state)
      IDLE: begin
        // A start arriving together with a stop is treated as noise
        if (rec_start && !rec_stop) begin
          doArm     = 1'b1;
          stateNext = ARMED;
        end
      end
      ARMED: begin
        // Leading silence is never recorded
        if (rec_stop) begin
          stateNext = FINAL;
        end else if (note_in != 3'd0) begin
          doLatch   = 1'b1;
          stateNext = TIMING;
        end
      end
      TIMING: begin
        if (rec_stop) begin
          // Stop beats a simultaneous change; a trailing rest is not worth keeping
          stateNext = FINAL;
          doClose   = (units != 8'd0) && (curNote != 3'd0);
        end else if (inChanged) begin
          // Anything held for less than one unit is a glitch and vanishes
          doLatch = 1'b1;
          doClose = (units != 8'd0);
        end else begin
          doCount = 1'b1;
          // The duration byte saturates: emit 255 and keep timing as a fresh entry
          if (tickWrap && (units == 8'd254)) begin
            doClose    = 1'b1;
            closeUnits = 8'd255;
          end
        end
        if (doClose && (entryCnt == MAX_LAST)) begin
          doFull    = 1'b1;
          stateNext = FINAL;
        end
      end
      FINAL: begin
        // Length byte goes out only once the last triple has drained
        if (wrPhase == 2'd0) begin
          writeLen  = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Timing counters, entry bookkeeping and the triple writer
  always_ff @(posedge clk) begin
    if (rst) begin
      curNote    <= 3'd0;
      curOct     <= 3'd0;
      tickCnt    <= '0;
      units      <= 8'd0;
      entryCnt   <= 8'd0;
      baseAddr   <= '0;
      fullReg    <= 1'b0;
      recDoneReg <= 1'b0;
      holdNote   <= 3'd0;
      holdOct    <= 3'd0;
      holdUnits  <= 8'd0;
      wrPhase    <= 2'd0;
    end else begin
      recDoneReg <= writeLen;

      if (doArm) begin
        entryCnt <= 8'd0;
        baseAddr <= ADDR_W'(1);
        fullReg  <= 1'b0;
        curNote  <= 3'd0;
        curOct   <= 3'd0;
        tickCnt  <= '0;
        units    <= 8'd0;
      end

      // The change cycle itself is the first counted cycle of the new entry
      if (doLatch) begin
        curNote <= note_in;
        curOct  <= inOct;
        tickCnt <= TICK_W'(1);
        units   <= 8'd0;
      end else if (doCount) begin
        if (tickWrap) begin
          tickCnt <= '0;
          units   <= (units == 8'd254) ? 8'd0 : units + 8'd1;
        end else begin
          tickCnt <= tickCnt + TICK_W'(1);
        end
      end

      if (doClose) begin
        holdNote  <= curNote;
        holdOct   <= curOct;
        holdUnits <= closeUnits;
        entryCnt  <= entryCnt + 8'd1;
      end

      if (doFull) begin
        fullReg <= 1'b1;
      end

      if (doClose) begin
        wrPhase <= 2'd1;
      end else if (wrPhase == 2'd3) begin
        wrPhase  <= 2'd0;
        baseAddr <= baseAddr + ADDR_W'(3);
      end else if (wrPhase != 2'd0) begin
        wrPhase <= wrPhase + 2'd1;
      end
    end
  end

  // Memory write port; address and data are parked at 0 whenever no byte is written
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = 8'd0;
    if (writeLen) begin
      wr_en   = 1'b1;
      wr_data = lenByte;
    end else begin
      case (wrPhase)
        2'd1: begin
          wr_en   = 1'b1;
          wr_addr = baseAddr;
          wr_data = {5'd0, holdNote};
        end
        2'd2: begin
          wr_en   = 1'b1;
          wr_addr = baseAddr + ADDR_W'(1);
          wr_data = {5'd0, holdOct};
        end
        2'd3: begin
          wr_en   = 1'b1;
          wr_addr = baseAddr + ADDR_W'(2);
          wr_data = holdUnits;
        end
        default: begin
          wr_en = 1'b0;
        end
      endcase
    end
  end

  assign recording = (state != IDLE);
  assign full      = fullReg;
  assign rec_done  = recDoneReg;

endmodule

// File: tb/tb_note_recorder.sv
// Directed bench for note_recorder: two instances (MAX_ENTRIES 84 and 2) share stimulus.
// Writes are logged on the falling edge and compared against hand-computed memory images.
// Inputs change 1 time unit after the rising edge.
module tb_note_recorder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       rec_start;
  logic       rec_stop;
  logic [2:0] note_in;
  logic [2:0] octave_in;

  logic       wrEnA, recA, fullA, doneA;
  logic [9:0] wrAddrA;
  logic [7:0] wrDataA;
  logic       wrEnB, recB, fullB, doneB;
  logic [9:0] wrAddrB;
  logic [7:0] wrDataB;

  note_recorder #(.TICK_CYCLES(4), .ADDR_W(10), .MAX_ENTRIES(84)) dutA (
    .clk(clk), .rst(rst), .rec_start(rec_start), .rec_stop(rec_stop),
    .note_in(note_in), .octave_in(octave_in),
    .wr_en(wrEnA), .wr_addr(wrAddrA), .wr_data(wrDataA),
    .recording(recA), .full(fullA), .rec_done(doneA)
  );

  note_recorder #(.TICK_CYCLES(4), .ADDR_W(10), .MAX_ENTRIES(2)) dutB (
    .clk(clk), .rst(rst), .rec_start(rec_start), .rec_stop(rec_stop),
    .note_in(note_in), .octave_in(octave_in),
    .wr_en(wrEnB), .wr_addr(wrAddrB), .wr_data(wrDataB),
    .recording(recB), .full(fullB), .rec_done(doneB)
  );

  int cyc = 0;
  int logAddrA[$], logDataA[$], logCycA[$];
  int logAddrB[$], logDataB[$];
  int doneCntA = 0, doneCycA = 0, doneCntB = 0;
  int idleBadA = 0, idleBadB = 0;

  // Write/pulse monitor
  always @(negedge clk) begin
    cyc++;
    if (wrEnA) begin
      logAddrA.push_back(int'(wrAddrA));
      logDataA.push_back(int'(wrDataA));
      logCycA.push_back(cyc);
    end else if (wrAddrA != 10'd0 || wrDataA != 8'd0) begin
      idleBadA++;
    end
    if (doneA) begin
      doneCntA++;
      doneCycA = cyc;
    end
    if (wrEnB) begin
      logAddrB.push_back(int'(wrAddrB));
      logDataB.push_back(int'(wrDataB));
    end else if (wrAddrB != 10'd0 || wrDataB != 8'd0) begin
      idleBadB++;
    end
    if (doneB) doneCntB++;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clearLogs();
    logAddrA.delete(); logDataA.delete(); logCycA.delete();
    logAddrB.delete(); logDataB.delete();
  endtask

  task automatic checkLog(input string tag, input int obsA[$], input int obsD[$],
                          input int expA[$], input int expD[$]);
    check({tag, " write count"}, obsA.size(), expA.size());
    for (int i = 0; i < expA.size() && i < obsA.size(); i++) begin
      check($sformatf("%s addr#%0d", tag, i), obsA[i], expA[i]);
      check($sformatf("%s data#%0d", tag, i), obsD[i], expD[i]);
    end
  endtask

  task automatic waitDone(input string tag, input bit useB, input int prev, input int budget);
    int n = 0;
    while (((useB ? doneCntB : doneCntA) == prev) && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check({tag, " rec_done seen"}, ((useB ? doneCntB : doneCntA) != prev) ? 1 : 0, 1);
  endtask

  task automatic startPulse();
    rec_start = 1'b1; step(1); rec_start = 1'b0;
  endtask

  task automatic stopPulse();
    note_in = 3'd0; rec_stop = 1'b1; step(1); rec_stop = 1'b0;
  endtask

  task automatic checkAllZeroA(input string tag);
    check({tag, " wr_en"}, int'(wrEnA), 0);
    check({tag, " wr_addr"}, int'(wrAddrA), 0);
    check({tag, " wr_data"}, int'(wrDataA), 0);
    check({tag, " recording"}, int'(recA), 0);
    check({tag, " full"}, int'(fullA), 0);
    check({tag, " rec_done"}, int'(doneA), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ea[$];
    int ed[$];
    int prev;
    int lastCyc;
    int zeroWrites;

    rst = 1'b1; rec_start = 1'b0; rec_stop = 1'b0; note_in = 3'd0; octave_in = 3'd1;
    step(3);
    checkAllZeroA("reset");
    rst = 1'b0;
    step(2);

    // Start together with stop while idle: nothing happens
    clearLogs();
    rec_start = 1'b1; rec_stop = 1'b1; step(1); rec_start = 1'b0; rec_stop = 1'b0;
    step(3);
    check("start+stop idle recording", int'(recA), 0);
    check("start+stop idle writes", logAddrA.size(), 0);

    // Test 1: single note, 12 cycles = 3 units; stop coincides with a change
    clearLogs(); prev = doneCntA;
    startPulse();
    check("t1 recording", int'(recA), 1);
    note_in = 3'd3; octave_in = 3'd2; step(12);
    stopPulse();
    waitDone("t1", 1'b0, prev, 30);
    ea = '{1, 2, 3, 0}; ed = '{3, 2, 3, 4};
    checkLog("t1", logAddrA, logDataA, ea, ed);
    lastCyc = (logCycA.size() > 0) ? logCycA[logCycA.size()-1] : -100;
    check("t1 done after length write", doneCycA - lastCyc, 1);
    check("t1 triple consecutive", (logCycA.size() > 2) ? logCycA[2] - logCycA[0] : -1, 2);
    step(3);
    check("t1 single done pulse", doneCntA - prev, 1);
    check("t1 recording low", int'(recA), 0);

    // Test 2: 2-cycle glitch dropped; start while recording is ignored
    clearLogs(); prev = doneCntA;
    startPulse();
    note_in = 3'd5; octave_in = 3'd1; step(2);
    note_in = 3'd2; step(3);
    rec_start = 1'b1; step(1); rec_start = 1'b0;
    step(4);
    stopPulse();
    waitDone("t2", 1'b0, prev, 30);
    ea = '{1, 2, 3, 0}; ed = '{2, 1, 2, 4};
    checkLog("t2", logAddrA, logDataA, ea, ed);

    // Test 3: rests recorded as (0,1); octave ignored during silence; trailing rest dropped
    clearLogs(); prev = doneCntA;
    startPulse();
    note_in = 3'd1; octave_in = 3'd1; step(8);
    note_in = 3'd0; octave_in = 3'd2; step(4);
    note_in = 3'd2; octave_in = 3'd1; step(4);
    note_in = 3'd0; octave_in = 3'd2; step(8);
    stopPulse();
    waitDone("t3", 1'b0, prev, 30);
    ea = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0}; ed = '{1, 1, 2, 0, 1, 1, 2, 1, 1, 10};
    checkLog("t3", logAddrA, logDataA, ea, ed);

    // Test 4: 1032 cycles saturates at 255 then continues; octave 5 coerced to 3
    clearLogs(); prev = doneCntA;
    startPulse();
    note_in = 3'd7; octave_in = 3'd5; step(1032);
    stopPulse();
    waitDone("t4", 1'b0, prev, 30);
    ea = '{1, 2, 3, 4, 5, 6, 0}; ed = '{7, 3, 255, 7, 3, 3, 7};
    checkLog("t4", logAddrA, logDataA, ea, ed);

    // Stop while still armed: empty recording, length 1
    clearLogs(); prev = doneCntA;
    octave_in = 3'd1;
    startPulse();
    rec_stop = 1'b1; step(1); rec_stop = 1'b0;
    waitDone("armed stop", 1'b0, prev, 20);
    ea = '{0}; ed = '{1};
    checkLog("armed stop", logAddrA, logDataA, ea, ed);

    // Test 5: MAX_ENTRIES=2 instance fills and finalizes on its own
    rst = 1'b1; step(2); rst = 1'b0; step(1);
    clearLogs(); prev = doneCntB;
    startPulse();
    note_in = 3'd1; octave_in = 3'd1; step(8);
    note_in = 3'd2; octave_in = 3'd2; step(8);
    note_in = 3'd3; octave_in = 3'd3; step(8);
    waitDone("t5", 1'b1, prev, 20);
    ea = '{1, 2, 3, 4, 5, 6, 0}; ed = '{1, 1, 2, 2, 2, 2, 7};
    checkLog("t5", logAddrB, logDataB, ea, ed);
    check("t5 full", int'(fullB), 1);
    check("t5 recording low", int'(recB), 0);
    step(8);
    check("t5 third note not written", logAddrB.size(), 7);
    stopPulse();
    step(10);
    check("t5 full sticky", int'(fullB), 1);
    startPulse();
    check("t5 full cleared by start", int'(fullB), 0);
    check("t5 recording after restart", int'(recB), 1);

    // Test 6: reset during the second triple write aborts the recording
    rst = 1'b1; step(2); rst = 1'b0; step(1);
    clearLogs(); prev = doneCntA;
    startPulse();
    note_in = 3'd1; octave_in = 3'd1; step(8);
    note_in = 3'd2; step(8);
    note_in = 3'd3; step(1);
    check("t6 second triple wr_en", int'(wrEnA), 1);
    check("t6 second triple addr", int'(wrAddrA), 4);
    step(1);
    check("t6 second triple addr+1", int'(wrAddrA), 5);
    rst = 1'b1; step(1);
    checkAllZeroA("t6 after reset");
    rst = 1'b0; note_in = 3'd0;
    step(20);
    check("t6 writes before abort", logAddrA.size(), 5);
    zeroWrites = 0;
    foreach (logAddrA[i]) if (logAddrA[i] == 0) zeroWrites++;
    check("t6 no length write", zeroWrites, 0);
    check("t6 no rec_done", doneCntA - prev, 0);

    check("A idle addr/data parked", idleBadA, 0);
    check("B idle addr/data parked", idleBadB, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
